div_unit: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the inverse counterpart of the shift-and-add multiplier and sits beside it in the execute stage. It accepts operands from the register file on a `start` pulse and returns a 32-bit quotient or remainder to write-back with a one-cycle `done` pulse. It implements the RISC-V divide-by-zero and signed-overflow results without trapping.

---
 rtl/rv32m_pkg.sv | 25 ++
 rtl/div_unit.sv | 148 ++++++++++++++
 tb/tb_div_unit.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M execute-stage units (divider and multiplier).
// Provides the data width, the divider operation and state encodings, and the
// architectural constants used for the divide-by-zero and overflow results.
package rv32m_pkg;

    localparam int XLEN = 32;

    // Encoding matches funct3[1:0] of the RV32M divide instructions.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV, DIVU, REM and REMU.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   start           : launch an operation when idle (ignored while busy)
//   op[1:0]         : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op1, op2        : dividend and divisor, sampled only in the start cycle
//   busy            : iterative operation in progress
//   done            : one-cycle pulse, result valid from this cycle onward
//   result          : quotient or remainder, held until the next completion
// Divide-by-zero and signed overflow complete in one cycle without iterating;
// all other operations take 32 shift/subtract cycles plus one sign-fix cycle.
module div_unit #(
    parameter int XLEN = rv32m_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import rv32m_pkg::*;

    div_state_e      state_q, state_d;
    div_op_e         op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic            is_signed;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] quo_fixed;
    logic [XLEN-1:0] rem_fixed;

    // Next-state logic. The dividend magnitude is loaded into the quotient
    // register so that shifting {rem, quo} feeds dividend bits into the
    // partial remainder MSB-first while quotient bits fill in from the LSB.
    // The trial subtract is one bit wider than XLEN because the shifted
    // partial remainder can momentarily exceed 32 bits.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        is_signed = ~op[0];
        trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
        quo_fixed = q_neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_fixed = r_neg_q ? (~rem_q + 1'b1) : rem_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = div_op_e'(op);
                    if (op2 == '0) begin
                        done_d   = 1'b1;
                        result_d = op[1] ? op1 : DIV_BY_ZERO_Q;
                    end else if (is_signed && (op1 == INT_MIN) && (op2 == '1)) begin
                        done_d   = 1'b1;
                        result_d = op[1] ? '0 : INT_MIN;
                    end else begin
                        state_d = CALC;
                        cnt_d   = 6'(XLEN);
                        rem_d   = '0;
                        quo_d   = (is_signed && op1[XLEN-1]) ? (~op1 + 1'b1) : op1;
                        dvsr_d  = (is_signed && op2[XLEN-1]) ? (~op2 + 1'b1) : op2;
                        q_neg_d = is_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                        r_neg_d = is_signed & op1[XLEN-1];
                    end
                end
            end
            CALC: begin
                if (!trial[XLEN]) begin
                    rem_d = trial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = op_q[1] ? rem_fixed : quo_fixed;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset discards any in-flight operation and
    // clears the visible outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= DIV;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases from the RV32M rules,
// busy/start interaction, asynchronous reset mid-operation, and randomized
// operations checked against a plain-arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checkCount = 0;
    int failCount  = 0;

    div_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model written directly from the RISC-V M-extension rules.
    function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            2'b10: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            2'b01: return a / b;
            default: return a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Waits (bounded) for done after E0, checking busy stays high meanwhile.
    // Entered at #1 after E0; returns at #1 after the done edge.
    task automatic waitDone(input string tag, input logic [31:0] expected);
        int lat;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) begin
                checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
                break;
            end
        end
        checkOutput({tag, "_lat"}, 32'(lat), 32'd33);
        checkOutput({tag, "_busyoff"}, 32'(busy), 32'd0);
        checkOutput({tag, "_res"}, result, expected);
    endtask

    // Launches one operation and checks latency, busy and result.
    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        if (isSpecial(o, a, b)) begin
            checkOutput({tag, "_done0"}, 32'(done), 32'd1);
            checkOutput({tag, "_busy0"}, 32'(busy), 32'd0);
            checkOutput({tag, "_res"}, result, expected);
        end else begin
            checkOutput({tag, "_busy0"}, 32'(busy), 32'd1);
            waitDone(tag, expected);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_hold"}, result, expected);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int doneSeen;
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        op1   = 32'd0;
        op2   = 32'd0;
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_res", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
        applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
        applyStimulus("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        applyStimulus("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        applyStimulus("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
        applyStimulus("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
        applyStimulus("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
        applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Start ignored while busy, then a new start in the done cycle.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        op1   = 32'hFFFF_FFFF;
        op2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        op1   = 32'd1;
        op2   = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("ign_busy", 32'(busy), 32'd1);
        checkOutput("ign_done", 32'(done), 32'd0);
        // Ten edges already consumed after E0; remaining wait counts from E10.
        doneSeen = 10;
        while (doneSeen < 40) begin
            @(posedge clk);
            #1;
            doneSeen++;
            if (done) break;
        end
        checkOutput("ign_lat", 32'(doneSeen), 32'd33);
        checkOutput("ign_res", result, 32'h5555_5555);
        start = 1'b1;
        op    = 2'b11;
        op1   = 32'd100;
        op2   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy", 32'(busy), 32'd1);
        checkOutput("b2b_done", 32'(done), 32'd0);
        waitDone("b2b", 32'd2);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        op1   = 32'd1000;
        op2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_res", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("arst_quiet", 32'(doneSeen), 32'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = randOperand();
            rB  = randOperand();
            applyStimulus($sformatf("rnd%0d", i), rOp, rA, rB, refModel(rOp, rA, rB));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
